// File: rtl/multi_key_debouncer.sv
// -----------------------------------------------------------------------------
// multi_key_debouncer
// Debounces N_KEYS independent mechanical keys on a single system clock.
// A shared sample strobe (tick) paces every channel's debounce FSM, so no
// derived clocks exist.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   key_raw       in   [N_KEYS] raw asynchronous key pins
//   key_down      out  [N_KEYS] debounced level, 1 = pressed
//   press_pulse   out  [N_KEYS] 1-clk pulse on accepted press
//   release_pulse out  [N_KEYS] 1-clk pulse on accepted release
//   long_press    out  [N_KEYS] 1-clk pulse once per hold after LONG_CNT ticks
//   tick          out  sample strobe, one clk every TICK_DIV clks
// -----------------------------------------------------------------------------
module multi_key_debouncer #(
   parameter int N_KEYS     = 4,
   parameter int F_CLK      = 50000000,
   parameter int F_SAMPLE   = 1000,
   parameter int STABLE_CNT = 20,
   parameter int LONG_CNT   = 1000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_down,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] long_press,
   output logic              tick
);

   localparam int TICK_DIV = F_CLK / F_SAMPLE;
   localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW       = $clog2(STABLE_CNT + 1);
   localparam int HW       = $clog2(LONG_CNT + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [TW-1:0] T_ZERO    = TW'(0);
   localparam logic [TW-1:0] T_ONE     = TW'(1);
   localparam logic [DW-1:0] D_ZERO    = DW'(0);
   localparam logic [DW-1:0] D_ONE     = DW'(1);
   localparam logic [DW-1:0] D_FULL    = DW'(STABLE_CNT);
   localparam logic [HW-1:0] H_ZERO    = HW'(0);
   localparam logic [HW-1:0] H_ONE     = HW'(1);
   localparam logic [HW-1:0] H_FULL    = HW'(LONG_CNT);
   // Raw pin level of a released key; also the synchronizer reset value.
   localparam logic          REL_LVL   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ARMING    = 2'd1,
      ST_PRESSED   = 2'd2,
      ST_RELEASING = 2'd3
   } state_t;

   logic [N_KEYS-1:0] r_sync1;
   logic [N_KEYS-1:0] r_sync2;
   logic [TW-1:0]     r_tick_cnt;
   logic              r_tick;
   state_t            r_state [N_KEYS];
   logic [DW-1:0]     r_dcnt  [N_KEYS];
   logic [HW-1:0]     r_hcnt  [N_KEYS];
   logic [N_KEYS-1:0] r_down;
   logic [N_KEYS-1:0] r_press;
   logic [N_KEYS-1:0] r_release;
   logic [N_KEYS-1:0] r_long;

   logic [N_KEYS-1:0] w_act;
   logic [DW-1:0]     w_dnext [N_KEYS];
   logic [HW-1:0]     w_hnext [N_KEYS];

   // Normalise polarity so that 1 always means pressed.
   assign w_act = r_sync2 ^ {N_KEYS{REL_LVL}};

   // Incremented counter values shared by the FSM branches.
   always_comb begin
      for (int i = 0; i < N_KEYS; i++) begin
         w_dnext[i] = r_dcnt[i] + D_ONE;
         w_hnext[i] = r_hcnt[i] + H_ONE;
      end
   end

   // Two-flop synchronizer per key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= {N_KEYS{REL_LVL}};
         r_sync2 <= {N_KEYS{REL_LVL}};
      end else begin
         r_sync1 <= key_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Sample strobe divider; the strobe is registered so it rises TICK_DIV clks after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt <= T_ZERO;
         r_tick     <= 1'b0;
      end else if (r_tick_cnt == TICK_LAST) begin
         r_tick_cnt <= T_ZERO;
         r_tick     <= 1'b1;
      end else begin
         r_tick_cnt <= r_tick_cnt + T_ONE;
         r_tick     <= 1'b0;
      end
   end

   // Per-channel debounce FSM with registered level and pulse outputs; advances only on tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_KEYS; i++) begin
            r_state[i] <= ST_IDLE;
            r_dcnt[i]  <= D_ZERO;
            r_hcnt[i]  <= H_ZERO;
         end
         r_down    <= {N_KEYS{1'b0}};
         r_press   <= {N_KEYS{1'b0}};
         r_release <= {N_KEYS{1'b0}};
         r_long    <= {N_KEYS{1'b0}};
      end else begin
         for (int i = 0; i < N_KEYS; i++) begin
            r_press[i]   <= 1'b0;
            r_release[i] <= 1'b0;
            r_long[i]    <= 1'b0;
            if (r_tick) begin
               case (r_state[i])
                  ST_IDLE: begin
                     if (w_act[i]) begin
                        if (STABLE_CNT == 1) begin
                           r_state[i] <= ST_PRESSED;
                           r_dcnt[i]  <= D_ZERO;
                           r_hcnt[i]  <= H_ONE;
                           r_press[i] <= 1'b1;
                           r_down[i]  <= 1'b1;
                        end else begin
                           r_state[i] <= ST_ARMING;
                           r_dcnt[i]  <= D_ONE;
                        end
                     end
                  end
                  ST_ARMING: begin
                     if (w_act[i]) begin
                        if (w_dnext[i] == D_FULL) begin
                           r_state[i] <= ST_PRESSED;
                           r_dcnt[i]  <= D_ZERO;
                           r_hcnt[i]  <= H_ONE;
                           r_press[i] <= 1'b1;
                           r_down[i]  <= 1'b1;
                        end else begin
                           r_dcnt[i] <= w_dnext[i];
                        end
                     end else begin
                        r_state[i] <= ST_IDLE;
                        r_dcnt[i]  <= D_ZERO;
                     end
                  end
                  ST_PRESSED: begin
                     if (w_act[i]) begin
                        // Saturating hold count; the pulse fires only on the step that reaches LONG_CNT.
                        if (r_hcnt[i] != H_FULL) begin
                           r_hcnt[i] <= w_hnext[i];
                           r_long[i] <= (w_hnext[i] == H_FULL);
                        end
                     end else if (STABLE_CNT == 1) begin
                        r_state[i]   <= ST_IDLE;
                        r_dcnt[i]    <= D_ZERO;
                        r_hcnt[i]    <= H_ZERO;
                        r_release[i] <= 1'b1;
                        r_down[i]    <= 1'b0;
                     end else begin
                        r_state[i] <= ST_RELEASING;
                        r_dcnt[i]  <= D_ONE;
                     end
                  end
                  ST_RELEASING: begin
                     if (!w_act[i]) begin
                        if (w_dnext[i] == D_FULL) begin
                           r_state[i]   <= ST_IDLE;
                           r_dcnt[i]    <= D_ZERO;
                           r_hcnt[i]    <= H_ZERO;
                           r_release[i] <= 1'b1;
                           r_down[i]    <= 1'b0;
                        end else begin
                           r_dcnt[i] <= w_dnext[i];
                        end
                     end else begin
                        // Bounce back to pressed: the hold continues, hcnt is kept.
                        r_state[i] <= ST_PRESSED;
                        r_dcnt[i]  <= D_ZERO;
                     end
                  end
                  default: begin
                     r_state[i] <= ST_IDLE;
                     r_dcnt[i]  <= D_ZERO;
                     r_hcnt[i]  <= H_ZERO;
                     r_down[i]  <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign key_down      = r_down;
   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign long_press    = r_long;
   assign tick          = r_tick;

endmodule

// File: doc/multi_key_debouncer.md
Name: multi_key_debouncer

Overview:
- Debounces N_KEYS independent mechanical keys on one system clock.
- Per-key level output, one-cycle press/release pulses and a one-shot long-press pulse.
- Replaces derived-clock debouncing with a shared clock-enable sample tick; all logic runs on clk.
- Sits between board key pins and keypad/UI logic in the KeyScan experiments.

Parameters:
- N_KEYS, 4, number of independent key channels
- F_CLK, 50000000, system clock frequency in Hz
- F_SAMPLE, 1000, sample tick frequency in Hz; TICK_DIV = F_CLK/F_SAMPLE (integer, >=2)
- STABLE_CNT, 20, consecutive agreeing samples required to accept a press or release (>=1)
- LONG_CNT, 1000, ticks of accepted press before long_press fires (>STABLE_CNT)
- ACTIVE_LOW, 1, 1: raw key pressed = 0; 0: raw key pressed = 1

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key_raw  input  N_KEYS  raw asynchronous key pins
- key_down  output  N_KEYS  debounced level, 1 = pressed
- press_pulse  output  N_KEYS  1-clk pulse on accepted press
- release_pulse  output  N_KEYS  1-clk pulse on accepted release
- long_press  output  N_KEYS  1-clk pulse once per hold after LONG_CNT ticks
- tick  output  1  sample strobe (exported for debug/other blocks)

Behaviour:
- Reset (async assert, sync release by clk): all outputs 0, every FSM in IDLE, all counters 0, synchronizer flops hold the released level.
- Synchronizer: 2-flop per key; act[i] = key_raw[i] XOR ACTIVE_LOW after sync (1 = pressed). Inputs are not otherwise filtered.
- Tick: counter 0..TICK_DIV-1, increments every clk, wraps to 0; tick = 1 for exactly one clk when counter == TICK_DIV-1. First tick occurs TICK_DIV clks after reset release.
- Per-channel FSM, evaluated only on clk with tick = 1 (state frozen otherwise):
  - IDLE: act=1 -> ARMING, dcnt=1; act=0 -> stay. If STABLE_CNT==1, act=1 goes directly to PRESSED.
  - ARMING: act=1 -> dcnt+1; when the sample makes dcnt==STABLE_CNT -> PRESSED. act=0 -> IDLE, dcnt=0.
  - PRESSED: act=1 -> hcnt+1 (saturating at LONG_CNT); act=0 -> RELEASING, dcnt=1.
  - RELEASING: act=0 -> dcnt+1; reaching STABLE_CNT -> IDLE. act=1 -> PRESSED, dcnt=0; hcnt keeps its value, the hold continues.
- Outputs, registered, valid the clk after the deciding tick:
  - key_down = 1 in PRESSED and RELEASING.
  - press_pulse on the ARMING->PRESSED (or IDLE->PRESSED) transition.
  - release_pulse on the RELEASING->IDLE transition.
  - long_press when hcnt first reaches LONG_CNT. hcnt is 1 on entry to PRESSED and counts accepted-press ticks including the entry tick. Fires at most once per hold; hcnt clears on IDLE.
- Counters: dcnt width clog2(STABLE_CNT+1), hcnt width clog2(LONG_CNT+1); neither wraps.
- Channels are fully independent; simultaneous events on several keys produce simultaneous pulses.
- A glitch shorter than one tick period between samples is invisible. Any disagreeing sample restarts the debounce count.
- Reset mid-press: outputs drop to 0 immediately, and no release_pulse is emitted. After release from reset, a still-held key is re-accepted as a new press after STABLE_CNT ticks.

Test Plan (F_CLK=1000, F_SAMPLE=100 -> TICK_DIV=10, STABLE_CNT=3, LONG_CNT=8, N_KEYS=4, ACTIVE_LOW=1):
- Reset then idle keys=4'hF for 200 clks -> tick every 10 clks, all outputs 0, no pulses.
- key_raw[0]=0 held clean -> press_pulse[0] one clk, key_down[0]=1 the clk after the 3rd low sample tick; other bits 0.
- key_raw[1] bounces low for 2 ticks, high 1 tick, then low 3 ticks -> exactly one press_pulse[1], after the final 3rd consecutive low sample.
- Hold key_raw[2]=0 for 12 ticks -> press at tick 3, long_press[2] single pulse when hcnt reaches 8 (7 ticks after press), none thereafter. Release 3 ticks -> release_pulse[2], key_down[2]=0. During release, one low sample mid-RELEASING keeps key_down=1 with no pulses.
- Keys 0 and 3 pressed on the same clk -> press_pulse=4'b1001 in the same cycle.
- Assert rst_n=0 while key_down[3]=1 -> all outputs 0 asynchronously, no release_pulse. Key still low after reset release -> new press_pulse[3] after 3 ticks.
